md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 132 +++++++++++++
 tb/tb_md_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy stalls the pipeline while an op runs.
// Optional madd/maddu accumulate ops are enabled by defining MD_UNIT_MADD_EN.
module md_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic [3:0]  md_op,
   input  logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
`endif

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   a;
   logic [31:0]   b;
   logic [3:0]    op;

   logic          is_mul;
   logic          is_div;
   logic          accept;

   always_comb begin
      is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MD_UNIT_MADD_EN
      is_mul = is_mul || (md_op == OP_MADD) || (md_op == OP_MADDU);
`endif
      is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
   end

   assign accept = start && (state == IDLE) && (is_mul || is_div);
   assign busy   = accept || (state == RUN);

   // Datapath works on latched operands, stable for the whole run.
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        sgn;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] dvs;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] q_out;
   logic [31:0] r_out;
   logic [63:0] nxt;

   always_comb begin
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'd0, a} * {32'd0, b};
      sgn    = (op == OP_DIV);
      abs_a  = (sgn && a[31]) ? -a : a;
      abs_b  = (sgn && b[31]) ? -b : b;
      dvs    = (abs_b == 32'd0) ? 32'd1 : abs_b;
      quo    = abs_a / dvs;
      rem    = abs_a % dvs;
      q_out  = (sgn && (a[31] ^ b[31])) ? -quo : quo;
      r_out  = (sgn && a[31]) ? -rem : rem;
   end

   always_comb begin
      nxt = {hi, lo};
      case (op)
         OP_MULT:  nxt = prod_s;
         OP_MULTU: nxt = prod_u;
         OP_DIV,
         OP_DIVU:  if (b != 32'd0) nxt = {r_out, q_out};
`ifdef MD_UNIT_MADD_EN
         OP_MADD:  nxt = {hi, lo} + prod_s;
         OP_MADDU: nxt = {hi, lo} + prod_u;
`endif
         default:  nxt = {hi, lo};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         a     <= '0;
         b     <= '0;
         op    <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state <= RUN;
                  a     <= op1;
                  b     <= op2;
                  op    <= md_op;
                  cnt   <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
               end else if (start && md_op == OP_MTHI) begin
                  hi <= op1;
               end else if (start && md_op == OP_MTLO) begin
                  lo <= op1;
               end
            end
            RUN: begin
               if (cnt == '0) begin
                  state    <= IDLE;
                  {hi, lo} <= nxt;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vectors plus random ops against a reference model.
module tb_md_unit;

   localparam int MULC = 5;
   localparam int DIVC = 10;

   logic        clk;
   logic        resetn;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [3:0]  md_op;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_chk  = 0;
   int n_fail = 0;
   logic [63:0] hl_m;

   md_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
      .clk(clk), .resetn(resetn), .op1(op1), .op2(op2),
      .md_op(md_op), .start(start), .busy(busy), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef MD_UNIT_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int cycles_of(input logic [3:0] o);
      if (o == 4'd1 || o == 4'd2) return MULC;
      if (o == 4'd3 || o == 4'd4) return DIVC;
      if (MADD_EN && (o == 4'd7 || o == 4'd8)) return MULC;
      return 0;
   endfunction

   // Architectural meaning of each op, using plain integer arithmetic.
   function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] hl);
      longint sx;
      longint sy;
      longint unsigned ux;
      longint unsigned uy;
      int qi;
      int ri;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (o)
         4'd1: return 64'(sx * sy);
         4'd2: return ux * uy;
         4'd3: begin
            if (y == 0) return hl;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            qi = $signed(x) / $signed(y);
            ri = $signed(x) % $signed(y);
            return {ri, qi};
         end
         4'd4: begin
            if (y == 0) return hl;
            return {x % y, x / y};
         end
         4'd5: return {x, hl[31:0]};
         4'd6: return {hl[63:32], x};
         4'd7: return MADD_EN ? hl + 64'(sx * sy) : hl;
         4'd8: return MADD_EN ? hl + ux * uy : hl;
         default: return hl;
      endcase
   endfunction

   // Called just after a falling edge; returns just after a later falling edge.
   task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit intrude);
      int n;
      logic [63:0] exp;
      n   = cycles_of(o);
      exp = ref_op(o, x, y, hl_m);
      start = 1'b1;
      md_op = o;
      op1   = x;
      op2   = y;
      #1 chk("busy_issue", {31'd0, busy}, {31'd0, n != 0});
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            md_op = 4'($urandom);
            op1   = $urandom;
            op2   = $urandom;
         end
         if (intrude && i == 2) begin
            start = 1'b1;
            md_op = 4'd1;
            op1   = $urandom;
            op2   = $urandom;
         end
         if (i == 3) start = 1'b0;
         #1 chk("busy_run", {31'd0, busy}, 32'd1);
         if (i == n) begin
            chk("hi_hold", hi, hl_m[63:32]);
            chk("lo_hold", lo, hl_m[31:0]);
         end
      end
      @(negedge clk);
      start = 1'b0;
      md_op = 4'($urandom);
      op1   = $urandom;
      op2   = $urandom;
      #1 chk("busy_done", {31'd0, busy}, 32'd0);
      chk("hi", hi, exp[63:32]);
      chk("lo", lo, exp[31:0]);
      hl_m = exp;
   endtask

   initial begin
      logic [3:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;
      resetn = 1'b0;
      start  = 1'b0;
      md_op  = 4'd0;
      op1    = 32'd0;
      op2    = 32'd0;
      hl_m   = 64'd0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      md_op = 4'd5;
      op1   = 32'hDEADBEEF;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      do_op(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFFE);
      do_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
      chk("multu_hi", hi, 32'h00000001);
      chk("multu_lo", lo, 32'hFFFFFFFE);
      do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
      chk("div_hi", hi, 32'hFFFFFFFF);
      chk("div_lo", lo, 32'hFFFFFFFD);
      do_op(4'd4, 32'd7, 32'd0, 1'b0);
      chk("divz_hi", hi, 32'hFFFFFFFF);
      chk("divz_lo", lo, 32'hFFFFFFFD);
      do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      chk("ovf_hi", hi, 32'h0);
      chk("ovf_lo", lo, 32'h80000000);
      do_op(4'd3, 32'd100, 32'hFFFFFFF9, 1'b1);

      do_op(4'd5, 32'h12345678, 32'd0, 1'b0);
      do_op(4'd6, 32'h9ABCDEF0, 32'd0, 1'b0);
      chk("mthi", hi, 32'h12345678);
      chk("mtlo", lo, 32'h9ABCDEF0);

      do_op(4'd5, 32'h55555555, 32'd0, 1'b0);
      do_op(4'd6, 32'h55555555, 32'd0, 1'b0);
      start = 1'b1;
      md_op = 4'd3;
      op1   = 32'd100;
      op2   = 32'd7;
      #1 chk("rdiv_issue", {31'd0, busy}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         start = 1'b0;
         #1 chk("rdiv_run", {31'd0, busy}, 32'd1);
      end
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("rdiv_busy", {31'd0, busy}, 32'd0);
      chk("rdiv_hi", hi, 32'd0);
      chk("rdiv_lo", lo, 32'd0);
      hl_m = 64'd0;
      repeat (12) @(negedge clk);
      #1;
      chk("rdiv_late_busy", {31'd0, busy}, 32'd0);
      chk("rdiv_late_hi", hi, 32'd0);
      chk("rdiv_late_lo", lo, 32'd0);
      @(negedge clk);

      do_op(4'd5, 32'd0, 32'd0, 1'b0);
      do_op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
      do_op(4'd8, 32'd1, 32'd1, 1'b0);
      chk("maddu_hi", hi, MADD_EN ? 32'h1 : 32'h0);
      chk("maddu_lo", lo, MADD_EN ? 32'h0 : 32'hFFFFFFFF);
      do_op(4'd7, 32'hFFFFFFFF, 32'd3, 1'b0);

      do_op(4'd0, 32'h11111111, 32'd5, 1'b0);
      for (int k = 9; k <= 15; k++) do_op(4'(k), $urandom, $urandom, 1'b0);

      for (int k = 0; k < 60; k++) begin
         ro = 4'($urandom_range(0, 15));
         rx = $urandom;
         ry = $urandom;
         case ($urandom_range(0, 3))
            0: ry = 32'd0;
            1: ry = 32'($urandom_range(1, 9));
            2: ry = 32'hFFFFFFFF;
            default: ;
         endcase
         if ($urandom_range(0, 7) == 0) rx = 32'h80000000;
         do_op(ro, rx, ry, $urandom_range(0, 3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
